ppbuffer_ctrl: RTL and testbench

Sequencing controller for the bit-serial ping-pong buffer (`PPBuffer`) in the WiMAX transmit chain. It sits between an upstream bit stream (randomizer/FEC side) and a downstream consumer (interleaver/modulator side). It generates the write and read addresses and enables for the two banks, tracks bank ownership, and applies backpressure in both directions. It carries no data. Data flows straight from the upstream source into the buffer and from buffer `q` to the consumer, aligned by this block's strobes.

---
 rtl/ppbuffer_ctrl.sv | 110 +++++++++++
 tb/tb_ppbuffer_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ppbuffer_ctrl.sv
// Address/strobe sequencer for a bit-serial two-bank ping-pong buffer.
// Writes fill one bank while the other drains; bank_full arbitrates ownership.
module ppbuffer_ctrl #(
  parameter int unsigned BLOCK_SIZE = 192,
  parameter int unsigned ADDR_W     = 9
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wraddress,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rdaddress,
  input  logic              out_ready,
  output logic              out_valid,
  output logic              out_first,
  output logic              out_last,
  output logic [1:0]        bank_full,
  output logic              err_overflow
);

  localparam int unsigned IDX_W = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(BLOCK_SIZE - 1);
  localparam logic [ADDR_W-1:0] BANK1_BASE = ADDR_W'(BLOCK_SIZE);

  logic             wr_bank, rd_bank;
  logic [IDX_W-1:0] wr_idx, rd_idx;

  logic             wr_bank_n, rd_bank_n;
  logic [IDX_W-1:0] wr_idx_n, rd_idx_n;
  logic [1:0]       bank_full_n;
  logic             out_valid_n, out_first_n, out_last_n, err_overflow_n;

  // Handshake strobes and physical addresses, all derived from registered state.
  always_comb begin
    in_ready  = resetN && !bank_full[wr_bank];
    wr_en     = in_valid && in_ready;
    rd_en     = resetN && bank_full[rd_bank] && (!out_valid || out_ready);
    wraddress = (wr_bank ? BANK1_BASE : '0) + ADDR_W'(wr_idx);
    rdaddress = (rd_bank ? BANK1_BASE : '0) + ADDR_W'(rd_idx);
  end

  // Next-state: index/bank advance, ownership flags, output qualifiers.
  always_comb begin
    wr_bank_n      = wr_bank;
    rd_bank_n      = rd_bank;
    wr_idx_n       = wr_idx;
    rd_idx_n       = rd_idx;
    bank_full_n    = bank_full;
    out_valid_n    = out_valid;
    out_first_n    = out_first;
    out_last_n     = out_last;
    err_overflow_n = err_overflow || (in_valid && !in_ready);

    if (wr_en) begin
      if (wr_idx == LAST_IDX) begin
        wr_idx_n             = '0;
        bank_full_n[wr_bank] = 1'b1;
        wr_bank_n            = !wr_bank;
      end else begin
        wr_idx_n = wr_idx + IDX_W'(1);
      end
    end

    // Reader only ever owns the bank the writer is not filling, so set/clear never collide.
    if (rd_en) begin
      if (rd_idx == LAST_IDX) begin
        rd_idx_n             = '0;
        bank_full_n[rd_bank] = 1'b0;
        rd_bank_n            = !rd_bank;
      end else begin
        rd_idx_n = rd_idx + IDX_W'(1);
      end
    end

    if (rd_en) begin
      out_valid_n = 1'b1;
      out_first_n = (rd_idx == '0);
      out_last_n  = (rd_idx == LAST_IDX);
    end else if (out_ready) begin
      out_valid_n = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      wr_bank      <= 1'b0;
      rd_bank      <= 1'b0;
      wr_idx       <= '0;
      rd_idx       <= '0;
      bank_full    <= 2'b00;
      out_valid    <= 1'b0;
      out_first    <= 1'b0;
      out_last     <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      wr_bank      <= wr_bank_n;
      rd_bank      <= rd_bank_n;
      wr_idx       <= wr_idx_n;
      rd_idx       <= rd_idx_n;
      bank_full    <= bank_full_n;
      out_valid    <= out_valid_n;
      out_first    <= out_first_n;
      out_last     <= out_last_n;
      err_overflow <= err_overflow_n;
    end
  end

endmodule

// File: tb/tb_ppbuffer_ctrl.sv
// Bench for ppbuffer_ctrl: a behavioural 1-cycle buffer carries the data, and a
// scoreboard queue of expected {bit, first, last} is checked by a separate monitor.
module tb_ppbuffer_ctrl;
  localparam int unsigned BS = 192;
  localparam int unsigned AW = 9;

  logic          clk = 1'b0;
  logic          resetN = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic          din = 1'b0;
  logic          q;
  logic          in_ready, wr_en, rd_en, out_valid, out_first, out_last, err_overflow;
  logic [AW-1:0] wraddress, rdaddress;
  logic [1:0]    bank_full;

  logic          mem [0:(1<<AW)-1];
  logic [2:0]    sbq [$];
  int            total = 0;
  int            bad = 0;
  int            push_cnt = 0;
  int            mode = 1;  // 0: out_ready=1, 1: out_ready=0, 2: random
  logic [31:0]   pat [0:5];

  ppbuffer_ctrl #(.BLOCK_SIZE(BS), .ADDR_W(AW)) dut (
    .clk(clk), .resetN(resetN), .in_valid(in_valid), .in_ready(in_ready),
    .wr_en(wr_en), .wraddress(wraddress), .rd_en(rd_en), .rdaddress(rdaddress),
    .out_ready(out_ready), .out_valid(out_valid), .out_first(out_first),
    .out_last(out_last), .bank_full(bank_full), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  // Two-bank buffer with one cycle of read latency.
  always @(posedge clk) begin
    if (wr_en) mem[wraddress] <= din;
    if (rd_en) q <= mem[rdaddress];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] addr_of(input int n);
    return AW'(((n / BS) % 2) * BS + (n % BS));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one bit; the caller states whether it must be accepted.
  task automatic drive_bit(input logic b, input logic exp_rdy);
    step();
    in_valid = 1'b1;
    din      = b;
    #1;
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    chk("wr_en", 32'(wr_en), 32'(exp_rdy));
    if (exp_rdy) begin
      chk("wraddress", 32'(wraddress), 32'(addr_of(push_cnt)));
      sbq.push_back({b, 1'(push_cnt % BS == 0), 1'(push_cnt % BS == BS - 1)});
      push_cnt++;
    end
  endtask

  task automatic idle();
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sbq.size() != 0 || out_valid) && n < 3000) begin
      step();
      n++;
    end
    if (n >= 3000) chk("drain_timeout", 32'(sbq.size()), 32'd0);
  endtask

  task automatic do_reset();
    step();
    resetN = 1'b0;
    sbq.delete();
    push_cnt = 0;
    step();
    step();
    resetN = 1'b1;
  endtask

  // Downstream acceptance pattern.
  initial forever begin
    @(posedge clk);
    #1;
    case (mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'b0;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: read-address order, stall behaviour, and scoreboard on accepted beats.
  initial begin
    int          rd_cnt = 0;
    logic        prev_stall = 1'b0;
    logic [AW-1:0] prev_ra = '0;
    logic [2:0]  e;
    forever begin
      @(negedge clk);
      if (!resetN) begin
        rd_cnt     = 0;
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) chk("rdaddr_hold", 32'(rdaddress), 32'(prev_ra));
        prev_stall = out_valid && !out_ready;
        prev_ra    = rdaddress;
        if (prev_stall) chk("rd_en_stall", 32'(rd_en), 32'd0);
        if (rd_en) begin
          chk("rdaddress", 32'(rdaddress), 32'(addr_of(rd_cnt)));
          rd_cnt++;
        end
        if (out_valid && out_ready) begin
          if (sbq.size() == 0) begin
            chk("unexpected_beat", 32'd1, 32'd0);
          end else begin
            e = sbq.pop_front();
            chk("q/first/last", {29'd0, q, out_first, out_last}, {29'd0, e});
          end
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit  seen;
    int  n;
    pat[0] = 32'h2833E48D; pat[1] = 32'h15A9C6F2; pat[2] = 32'h7E01B3D4;
    pat[3] = 32'hC0FFEE11; pat[4] = 32'h9A5B3C77; pat[5] = 32'h0D1E48CA;

    // Reset held for 3 cycles with in_valid high: everything quiet.
    in_valid = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_wr_en", 32'(wr_en), 32'd0);
      chk("rst_rd_en", 32'(rd_en), 32'd0);
      chk("rst_out", {29'd0, out_valid, out_first, out_last}, 32'd0);
      chk("rst_bank_full", 32'(bank_full), 32'd0);
      chk("rst_addr", {wraddress, rdaddress}, 32'd0);
      chk("rst_err", 32'(err_overflow), 32'd0);
    end
    in_valid = 1'b0;
    resetN   = 1'b1;
    #1;
    chk("release_in_ready", 32'(in_ready), 32'd1);
    mode = 0;

    // One reference block, then bank 0 full and first read in the next cycle.
    for (int k = 0; k < int'(BS); k++) drive_bit(pat[k / 32][31 - (k % 32)], 1'b1);
    idle();
    #1;
    chk("blk_bank_full", 32'(bank_full), 32'd1);
    chk("blk_first_rd_en", 32'(rd_en), 32'd1);
    chk("blk_first_rdaddr", 32'(rdaddress), 32'd0);
    chk("blk_out_valid_pre", 32'(out_valid), 32'd0);
    wait_drain();

    // Ten back-to-back blocks: in_ready never drops, banks alternate.
    for (int k = 0; k < 10 * int'(BS); k++) drive_bit(1'($urandom_range(0, 1)), 1'b1);
    idle();
    wait_drain();

    // Overflow: consumer stalled, 400 bits offered, only 384 fit.
    do_reset();
    mode = 1;
    for (int k = 0; k < 400; k++) begin
      drive_bit(1'($urandom_range(0, 1)), 1'(k < 384));
      if (k == 384) begin
        chk("ovf_bank_full", 32'(bank_full), 32'd3);
        chk("ovf_err_before", 32'(err_overflow), 32'd0);
      end
      if (k == 385) chk("ovf_err_set", 32'(err_overflow), 32'd1);
    end
    idle();
    mode = 0;
    seen = 1'b0;
    n = 0;
    while (n < 600) begin
      step();
      #1;
      if (seen) begin
        chk("ovf_ready_return", 32'(in_ready), 32'd1);
        break;
      end
      chk("ovf_ready_low", 32'(in_ready), 32'd0);
      if (rd_en && rdaddress == AW'(BS - 1)) seen = 1'b1;
      n++;
    end
    if (n >= 600) chk("ovf_drain_timeout", 32'd1, 32'd0);
    wait_drain();
    chk("ovf_err_sticky", 32'(err_overflow), 32'd1);

    // Random backpressure on a single block.
    mode = 2;
    for (int k = 0; k < int'(BS); k++) drive_bit(1'($urandom_range(0, 1)), 1'b1);
    idle();
    wait_drain();

    // Mid-block reset: bank 1 full, writer at index 100 of bank 0.
    mode = 1;
    for (int k = 0; k < int'(BS) + 100; k++) drive_bit(1'($urandom_range(0, 1)), 1'b1);
    idle();
    #1;
    chk("mid_bank_full", 32'(bank_full), 32'd2);
    chk("mid_wraddress", 32'(wraddress), 32'd100);
    chk("mid_err", 32'(err_overflow), 32'd1);
    resetN = 1'b0;
    sbq.delete();
    push_cnt = 0;
    step();
    #1;
    chk("mid_rst_bank_full", 32'(bank_full), 32'd0);
    chk("mid_rst_addr", {wraddress, rdaddress}, 32'd0);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_err", 32'(err_overflow), 32'd0);
    step();
    resetN = 1'b1;
    #1;
    chk("mid_release_ready", 32'(in_ready), 32'd1);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
